irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Memory-mapped interrupt controller feeding the single-cycle MIPS datapath's hwint[3:0] inputs.
//  - Edge-detects "done" pulses/levels from peripherals and latches them as pending.
//  - Applies a software mask and drives the masked pending vector onto hwint; the CP0 cause/status/EPC
//    logic consumes it.
//  - Software polls or acknowledges through four word registers on the data bus, decoded beside dmem.
// PARAMETERS
//  NSRC      4            number of interrupt sources (1..16)
//  BASE_ADDR 32'h0000_0800 byte address of register 0; 16-byte window, word aligned
// PORTS
//  clk     in   1     system clock, all state on rising edge
//  reset   in   1     synchronous, active-high reset
//  src     in   NSRC  peripheral done flags, synchronous to clk, any width pulse/level
//  we      in   1     data-bus write enable (memwrite)
//  addr    in   32    data-bus byte address (aluout)
//  wd      in   32    data-bus write data (writedata)
//  sel     out  1     1 when addr in [BASE_ADDR, BASE_ADDR+15]; steers readdata mux
//  rd      out  32    read data, combinational; 0 when sel=0
//  hwint   out  NSRC  pend & mask, to datapath hwint
// BEHAVIOUR
//  Reset (reset=1 at a clk edge)
//  - pend=0, ovf=0, mask=0, so hwint=0.
//  - src_q<=src, so a source already high at reset release is NOT an edge.
//  - reset dominates any write or edge that cycle.
//  Edge detect
//  - src_q<=src every cycle. edge[i] = src[i] & ~src_q[i].
//  - pend[i] sets at the clk edge that samples edge[i]=1.
//  - Latency: src rises in cycle n; pend and hwint high in cycle n+1.
//  - A held-high src produces exactly one edge.
//  Register map (addr[3:2]; addr[1:0] ignored; valid only when sel=1)
//  - 0 PEND
//    - rd = {ovf[NSRC-1:0] at bits 16+, pend at bits 0+}, other bits 0.
//    - Write = write-1-to-clear: pend &= ~wd[NSRC-1:0], ovf &= ~wd[16+NSRC-1:16].
//  - 1 MASK: RW, bits [NSRC-1:0]; upper bits read 0, writes ignored.
//  - 2 ID: RO, writes ignored.
//    - rd = {valid, 26'b0, id[4:0]}, valid at bit 31.
//    - id = lowest index i with (pend & mask)[i]=1, i.e. index 0 is highest priority.
//    - valid=0 and id=0 when none.
//  - 3 RAW: RO, rd = src (current, unregistered), zero-extended.
//  Overflow
//  - edge[i] while pend[i] already 1 and not being cleared that cycle sets sticky ovf[i].
//  - pend[i] stays 1; the event count is lost.
//  Simultaneous events
//  - Same cycle, W1C of pend[i] and edge[i]: set wins, pend[i]=1, ovf[i] unchanged.
//  - MASK write and edge in the same cycle are independent.
//  - hwint uses registered pend and mask; no combinational path from src or wd to hwint.
//  Masking
//  - mask[i]=0 still latches pend[i]; it only gates hwint and ID.
//  - Unmasking a pending source raises hwint the next cycle.
//  Bus
//  - we with sel=0 has no effect.
//  - Reads are side-effect free; only writes clear.
// TESTING
//  1. Reset: hold src=4'b0010 through reset, release, run 5 cycles -> pend=0, hwint=0, RAW reads 32'h2.
//  2. Latch/latency: mask=4'hF, 1-cycle pulse on src[2] in cycle n -> hwint=4'b0100 from n+1;
//     ID reads 32'h8000_0002; W1C wd=32'h4 -> hwint=0 next cycle.
//  3. Priority/mask: mask=4'b1010, pulse src[3] and src[1] together -> hwint=4'b1010, ID=32'h8000_0001.
//     Write mask=4'b1000 -> ID=32'h8000_0003.
//  4. Overflow: pulse src[0] twice without clearing -> PEND reads 32'h0001_0001;
//     W1C 32'h0001_0001 -> PEND reads 0.
//  5. Set-vs-clear race: W1C pend[1] in the same cycle as a src[1] rising edge -> pend[1]=1, ovf[1]=0.
//  6. Decode: write/read at BASE_ADDR+16 and BASE_ADDR-4 -> sel=0, rd=0, no state change;
//     MASK write 32'hFFFF_FFFF reads back 32'hF.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Data-bus port of the interrupt controller, decoded beside dmem.
// No valid/ready: a write commits at the rising edge where we=1 and sel=1;
// reads are combinational and side-effect free, rd=0 whenever sel=0.
interface irq_ctrl_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        sel;
  logic [31:0] rd;

  modport master (output we, addr, wd, input sel, rd);
  modport slave  (input we, addr, wd, output sel, rd);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detects peripheral done flags into sticky pending
// bits, masks them onto hwint, and exposes PEND/MASK/ID/RAW word registers.
module irq_ctrl #(
  parameter int          NSRC      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0800
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  irq_ctrl_if.slave       bus,
  output logic [NSRC-1:0] hwint
);

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] ovf;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr_pend;
  logic [NSRC-1:0] clr_ovf;
  logic [NSRC-1:0] active;
  logic [1:0]      reg_idx;
  logic            wr_pend;
  logic            wr_mask;
  logic            id_valid;
  logic [4:0]      id;
  logic [31:0]     rd_mux;
  logic            unused_bits;

  // 16-byte window: everything above the register index must match the base.
  assign bus.sel  = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign reg_idx  = bus.addr[3:2];
  assign wr_pend  = bus.we & bus.sel & (reg_idx == 2'd0);
  assign wr_mask  = bus.we & bus.sel & (reg_idx == 2'd1);
  assign unused_bits = &{1'b0, bus.addr[1:0], bus.wd};

  assign rise     = src & ~src_q;
  assign clr_pend = wr_pend ? bus.wd[NSRC-1:0] : '0;
  assign clr_ovf  = wr_pend ? bus.wd[16 +: NSRC] : '0;
  assign active   = pend & mask;
  assign hwint    = active;

  always_ff @(posedge clk) begin
    src_q <= src;
    if (reset) begin
      pend <= '0;
      ovf  <= '0;
      mask <= '0;
    end else begin
      // A new edge beats a same-cycle clear; overflow only when the old
      // pending bit survives, i.e. it is not being cleared.
      pend <= (pend & ~clr_pend) | rise;
      ovf  <= (ovf & ~clr_ovf) | (rise & pend & ~clr_pend);
      if (wr_mask) mask <= bus.wd[NSRC-1:0];
    end
  end

  // Lowest active index wins, so scan from the top and let lower bits override.
  always_comb begin
    id_valid = 1'b0;
    id       = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        id_valid = 1'b1;
        id       = 5'(i);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (bus.sel) begin
      case (reg_idx)
        2'd0: begin
          rd_mux[NSRC-1:0]  = pend;
          rd_mux[16 +: NSRC] = ovf;
        end
        2'd1:    rd_mux[NSRC-1:0] = mask;
        2'd2:    rd_mux = {id_valid, 26'b0, id};
        default: rd_mux[NSRC-1:0] = src;
      endcase
    end
  end

  assign bus.rd = rd_mux;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus randomized traffic checked
// against a per-source behavioural model of pending/overflow/mask.
module tb_irq_ctrl;
  localparam int          NSRC = 4;
  localparam logic [31:0] BASE = 32'h0000_0800;

  logic            clk;
  logic            reset;
  logic [NSRC-1:0] src;
  logic [NSRC-1:0] hwint;
  irq_ctrl_if      bus ();

  irq_ctrl #(.NSRC(NSRC), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .bus   (bus),
    .hwint (hwint)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state, one entry per source
  bit m_pend [NSRC];
  bit m_ovf  [NSRC];
  bit m_mask [NSRC];
  bit m_prev [NSRC];

  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd15);
  endfunction

  function automatic logic [31:0] model_hwint();
    logic [31:0] v = 0;
    for (int i = 0; i < NSRC; i++)
      if (m_pend[i] && m_mask[i]) v += 32'(1) << i;
    return v;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] v = 0;
    int idx;
    if (!in_window(a)) return 0;
    idx = int'((a - BASE) / 4);
    case (idx)
      0: for (int i = 0; i < NSRC; i++) begin
           if (m_pend[i]) v += 32'(1) << i;
           if (m_ovf[i])  v += 32'(1) << (16 + i);
         end
      1: for (int i = 0; i < NSRC; i++) if (m_mask[i]) v += 32'(1) << i;
      2: for (int i = 0; i < NSRC; i++)
           if (m_pend[i] && m_mask[i]) return 32'h8000_0000 + 32'(i);
      default: v = 32'(src);
    endcase
    return v;
  endfunction

  // Apply one clock of the specification's rules to the model.
  task automatic model_step();
    bit pend_wr = bus.we && in_window(bus.addr) && ((bus.addr - BASE) / 4 == 0);
    bit mask_wr = bus.we && in_window(bus.addr) && ((bus.addr - BASE) / 4 == 1);
    for (int i = 0; i < NSRC; i++) begin
      bit rose = src[i] && !m_prev[i];
      bit clr  = pend_wr && bus.wd[i];
      bit clro = pend_wr && bus.wd[16 + i];
      if (reset) begin
        m_pend[i] = 0; m_ovf[i] = 0; m_mask[i] = 0;
      end else begin
        if (rose && m_pend[i] && !clr) m_ovf[i] = 1;
        else if (clro)                 m_ovf[i] = 0;
        if (rose)     m_pend[i] = 1;
        else if (clr) m_pend[i] = 0;
        if (mask_wr) m_mask[i] = bus.wd[i];
      end
      m_prev[i] = src[i];
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("hwint", 32'(hwint), model_hwint());
  endtask

  task automatic bus_idle();
    bus.we = 1'b0; bus.addr = 32'h0; bus.wd = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.addr = a; bus.wd = d;
    cycle();
    bus_idle();
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.we = 1'b0; bus.addr = a;
    #1;
    check(tag, bus.rd, exp);
    check({tag, "_model"}, bus.rd, model_rd(a));
    bus.addr = 32'h0;
  endtask

  task automatic check_all_regs();
    for (int r = 0; r < 4; r++) begin
      bus.we = 1'b0; bus.addr = BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
      #1;
      exp_q.push_back(model_rd(bus.addr));
      check("reg_rd", bus.rd, exp_q.pop_front());
      check("reg_sel", 32'(bus.sel), 32'(1));
    end
    bus.addr = 32'h0;
  endtask

  initial begin
    logic [31:0] a;
    bus_idle();
    // 1: source high through reset is not an edge
    src = 4'b0010; reset = 1'b1;
    for (int k = 0; k < 2; k++) cycle();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    check("rst_hwint", 32'(hwint), 32'h0);
    rd_chk("rst_pend", BASE, 32'h0);
    rd_chk("rst_raw", BASE + 12, 32'h2);
    src = 4'b0000; cycle();

    // 2: latch, latency, W1C
    wr(BASE + 4, 32'hF);
    src = 4'b0100;
    #1 check("no_comb_path", 32'(hwint), 32'h0);
    cycle();
    src = 4'b0000;
    check("lat_hwint", 32'(hwint), 32'h4);
    rd_chk("lat_id", BASE + 8, 32'h8000_0002);
    wr(BASE, 32'h4);
    check("w1c_hwint", 32'(hwint), 32'h0);

    // 3: priority and mask
    wr(BASE + 4, 32'hA);
    src = 4'b1010; cycle(); src = 4'b0000;
    check("prio_hwint", 32'(hwint), 32'hA);
    rd_chk("prio_id", BASE + 8, 32'h8000_0001);
    wr(BASE + 4, 32'h8);
    rd_chk("mask_id", BASE + 8, 32'h8000_0003);
    wr(BASE, 32'hF);
    rd_chk("empty_id", BASE + 8, 32'h0);

    // 4: overflow
    src = 4'b0001; cycle(); src = 4'b0000; cycle();
    src = 4'b0001; cycle(); src = 4'b0000; cycle();
    rd_chk("ovf_pend", BASE, 32'h0001_0001);
    wr(BASE, 32'h0001_0001);
    rd_chk("ovf_clr", BASE, 32'h0);

    // 5: set beats clear, no overflow
    src = 4'b0010; cycle(); src = 4'b0000; cycle();
    src = 4'b0010;
    wr(BASE, 32'h2);
    rd_chk("race_pend", BASE, 32'h2);
    wr(BASE, 32'h2);
    rd_chk("race_clr", BASE, 32'h0);
    src = 4'b0000; cycle();

    // 6: decode boundaries
    foreach (exp_q[i]) exp_q.delete();
    a = BASE + 16;
    bus.we = 1'b1; bus.addr = a; bus.wd = 32'hFFFF_FFFF;
    #1 check("hi_sel", 32'(bus.sel), 32'h0);
    check("hi_rd", bus.rd, 32'h0);
    cycle(); bus_idle();
    a = BASE - 4;
    bus.we = 1'b1; bus.addr = a; bus.wd = 32'hFFFF_FFFF;
    #1 check("lo_sel", 32'(bus.sel), 32'h0);
    check("lo_rd", bus.rd, 32'h0);
    cycle(); bus_idle();
    rd_chk("decode_mask", BASE + 4, 32'h8);
    wr(BASE + 4, 32'hFFFF_FFFF);
    rd_chk("mask_rb", BASE + 4, 32'hF);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 60) == 0);
      src   = NSRC'($urandom_range(0, 15));
      bus.we = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       bus.addr = BASE + 16 + 32'($urandom_range(0, 7));
        1:       bus.addr = BASE - 4;
        default: bus.addr = BASE + 32'($urandom_range(0, 15));
      endcase
      bus.wd = $urandom();
      cycle();
      reset = 1'b0;
      bus_idle();
      check_all_regs();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
